game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Parametrised game lifecycle controller; successor to the two-state start/stop register.
//  Decodes 2-bit function commands into a five-state FSM: IDLE, COUNTDOWN, RUNNING, PAUSED, STOPPED.
//  Adds a pre-start countdown, a pause/resume toggle, a pause auto-timeout and a run-time counter.
//  Sits between the input decoder (en/func) and the display/score logic that consume game_state.
// PARAMETERS
//  STATE_W        8      width of game_state output
//  GAME_IDLE      8'h00  encoding driven in IDLE
//  GAME_COUNTDOWN 8'h02  encoding driven in COUNTDOWN
//  GAME_START     8'h01  encoding driven in RUNNING
//  GAME_PAUSE     8'h03  encoding driven in PAUSED
//  GAME_STOP      8'h04  encoding driven in STOPPED
//  COUNTDOWN_CYC  16     cycles spent in COUNTDOWN; 0 = go straight to RUNNING
//  PAUSE_TIMEOUT  1000   PAUSED cycles before forced stop; 0 = never times out
//  TIME_W         32     width of run_cycles counter
// PORTS
//  clk            in   1        system clock, all state on rising edge
//  rst_n          in   1        asynchronous active-low reset
//  en             in   1        command strobe; func sampled only when en=1
//  func           in   2        00 none, 01 start, 10 end, 11 pause/resume toggle
//  game_state     out  STATE_W  encoding of current FSM state
//  state_changed  out  1        one-cycle pulse, high in first cycle of a new state
//  countdown_left out  16       remaining COUNTDOWN cycles (0 outside COUNTDOWN)
//  pause_timeout  out  1        sticky: last stop was caused by the pause timeout
//  run_cycles     out  TIME_W   cycles spent in RUNNING since last start, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, game_state=GAME_IDLE, all other outputs 0.
//  Latency: command sampled at edge N (en=1); new game_state visible after edge N; state_changed high that cycle.
//  en=0 or func=00: no command; internal timers still advance.
//  IDLE:      start -> COUNTDOWN, countdown_left<=COUNTDOWN_CYC-1 (COUNTDOWN_CYC=0: -> RUNNING); others ignored.
//  COUNTDOWN: countdown_left decrements each cycle; at 0 -> RUNNING next edge.
//             end -> STOPPED (abort); start/toggle ignored.
//  RUNNING:   run_cycles +1 per cycle, saturates at all-ones; end -> STOPPED; toggle -> PAUSED; start ignored.
//  PAUSED:    internal pause counter starts at 0 on entry, +1 per cycle; toggle -> RUNNING; end -> STOPPED.
//             counter reaching PAUSE_TIMEOUT-1 with no command -> STOPPED, pause_timeout<=1.
//             Explicit command on the timeout cycle wins; pause_timeout stays 0.
//             pause counter clears on every PAUSED entry (no accumulation across pauses).
//  STOPPED:   holds; run_cycles frozen; start -> COUNTDOWN, clears pause_timeout and run_cycles.
//  run_cycles cleared on every COUNTDOWN entry; counts only in RUNNING (not COUNTDOWN/PAUSED).
//  state_changed never asserts for ignored commands or self-loops.
//  Unreachable FSM encodings recover to IDLE next edge.
//  Reset mid-countdown/pause: immediate return to IDLE, all counters cleared.
// TESTING
//  COUNTDOWN_CYC=4: reset, en=1 func=01 at edge 0 -> COUNTDOWN, countdown_left 3,2,1,0, RUNNING after edge 4.
//  RUNNING 10 cycles, toggle, wait 5, toggle, 3 cycles, end -> run_cycles=13, game_state=GAME_STOP.
//  PAUSE_TIMEOUT=8: enter PAUSED, no command -> STOPPED after 8th PAUSED cycle, pause_timeout=1; start clears it.
//  Toggle on exact timeout cycle -> RUNNING, pause_timeout=0; end in COUNTDOWN -> STOPPED.
//  en=0 with func=01 in IDLE for 5 cycles -> stays GAME_IDLE, state_changed never high.
//  rst_n low mid-COUNTDOWN (async, between edges) -> game_state=GAME_IDLE at once, counters 0.

Source files
------------

// File: rtl/game_state_if.sv
// game_state_if: command strobe in, lifecycle state/status out
interface game_state_if #(
    parameter int STATE_W = 8,
    parameter int TIME_W  = 32
);
    logic               en;
    logic [1:0]         func;
    logic [STATE_W-1:0] game_state;
    logic               state_changed;
    logic [15:0]        countdown_left;
    logic               pause_timeout;
    logic [TIME_W-1:0]  run_cycles;

    modport master (
        output en, func,
        input  game_state, state_changed, countdown_left, pause_timeout, run_cycles
    );
    modport slave (
        input  en, func,
        output game_state, state_changed, countdown_left, pause_timeout, run_cycles
    );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: five-state game lifecycle FSM with countdown, pause timeout and run timer
module game_state_ctrl #(
    parameter int                 STATE_W        = 8,
    parameter logic [STATE_W-1:0] GAME_IDLE      = STATE_W'(0),
    parameter logic [STATE_W-1:0] GAME_COUNTDOWN = STATE_W'(2),
    parameter logic [STATE_W-1:0] GAME_START     = STATE_W'(1),
    parameter logic [STATE_W-1:0] GAME_PAUSE     = STATE_W'(3),
    parameter logic [STATE_W-1:0] GAME_STOP      = STATE_W'(4),
    parameter int                 COUNTDOWN_CYC  = 16,
    parameter int                 PAUSE_TIMEOUT  = 1000,
    parameter int                 TIME_W         = 32
) (
    input logic        clk,
    input logic        rst_n,
    game_state_if.slave bus
);
    localparam int          PW      = PAUSE_TIMEOUT > 2 ? $clog2(PAUSE_TIMEOUT) : 1;
    localparam logic [PW-1:0] PT_LAST = PW'(PAUSE_TIMEOUT - 1);
    localparam logic [15:0] CD_INIT = 16'(COUNTDOWN_CYC == 0 ? 0 : COUNTDOWN_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_RUN, S_PAUSE, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cd_q, cd_d;
    logic [TIME_W-1:0]  run_q, run_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic               pto_q, pto_d;
    logic               chg_q, chg_d;
    logic               do_start, do_end, do_tog;

    assign do_start = bus.en && bus.func == 2'b01;
    assign do_end   = bus.en && bus.func == 2'b10;
    assign do_tog   = bus.en && bus.func == 2'b11;

    always_comb begin
        state_d = state_q;
        cd_d    = 16'd0;
        run_d   = run_q;
        pcnt_d  = '0;
        pto_d   = pto_q;
        case (state_q)
            S_IDLE, S_STOP: if (do_start) begin
                state_d = COUNTDOWN_CYC == 0 ? S_RUN : S_COUNT;
                cd_d    = CD_INIT;
                run_d   = '0;
                pto_d   = 1'b0;
            end
            S_COUNT: begin
                state_d = do_end ? S_STOP : (cd_q == 16'd0 ? S_RUN : S_COUNT);
                cd_d    = (do_end || cd_q == 16'd0) ? 16'd0 : cd_q - 16'd1;
            end
            S_RUN: begin
                run_d   = &run_q ? run_q : run_q + 1'b1;
                state_d = do_end ? S_STOP : (do_tog ? S_PAUSE : S_RUN);
            end
            S_PAUSE: begin
                pcnt_d = pcnt_q + 1'b1;
                // an explicit end/toggle on the last pause cycle beats the timeout
                if (do_end) state_d = S_STOP;
                else if (do_tog) state_d = S_RUN;
                else if (PAUSE_TIMEOUT != 0 && pcnt_q == PT_LAST) begin
                    state_d = S_STOP;
                    pto_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        chg_d = state_d != state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cd_q    <= 16'd0;
            run_q   <= '0;
            pcnt_q  <= '0;
            pto_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            run_q   <= run_d;
            pcnt_q  <= pcnt_d;
            pto_q   <= pto_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.game_state     = state_q == S_COUNT ? GAME_COUNTDOWN :
                                state_q == S_RUN   ? GAME_START :
                                state_q == S_PAUSE ? GAME_PAUSE :
                                state_q == S_STOP  ? GAME_STOP : GAME_IDLE;
    assign bus.state_changed  = chg_q;
    assign bus.countdown_left = cd_q;
    assign bus.pause_timeout  = pto_q;
    assign bus.run_cycles     = run_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed stimulus against a per-cycle behavioural model plus literal pins
module tb_game_state_ctrl;
    localparam int CD = 4;
    localparam int PT = 8;
    localparam logic [7:0] E_IDLE = 8'h00, E_CD = 8'h02, E_RUN = 8'h01, E_PAUSE = 8'h03, E_STOP = 8'h04;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0]  ms;
    int          mcd, mage;
    logic [31:0] mrun;
    logic        mpto, mchg;

    game_state_if #(.STATE_W(8), .TIME_W(32)) bus ();

    game_state_ctrl #(.COUNTDOWN_CYC(CD), .PAUSE_TIMEOUT(PT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = E_IDLE; mcd = 0; mage = 0; mrun = 0; mpto = 0; mchg = 0;
    endtask

    task automatic model_step(input logic e, input logic [1:0] f);
        logic [7:0] prev;
        logic st, nd, tg;
        if (!rst_n) begin
            model_reset();
            return;
        end
        prev = ms;
        st = e && f == 2'b01;
        nd = e && f == 2'b10;
        tg = e && f == 2'b11;
        if (ms == E_IDLE || ms == E_STOP) begin
            if (st) begin
                ms = CD > 0 ? E_CD : E_RUN;
                mcd = CD > 0 ? CD - 1 : 0;
                mrun = 0;
                mpto = 0;
            end
        end else if (ms == E_CD) begin
            if (nd) begin ms = E_STOP; mcd = 0; end
            else if (mcd == 0) ms = E_RUN;
            else mcd = mcd - 1;
        end else if (ms == E_RUN) begin
            if (mrun != 32'hFFFF_FFFF) mrun = mrun + 1;
            if (nd) ms = E_STOP;
            else if (tg) begin ms = E_PAUSE; mage = 0; end
        end else if (ms == E_PAUSE) begin
            if (nd) ms = E_STOP;
            else if (tg) ms = E_RUN;
            else if (mage == PT - 1) begin ms = E_STOP; mpto = 1; end
            else mage = mage + 1;
        end
        mchg = ms != prev;
    endtask

    task automatic compare();
        check("game_state", 32'(bus.game_state), 32'(ms));
        check("state_changed", 32'(bus.state_changed), 32'(mchg));
        check("countdown_left", 32'(bus.countdown_left), 32'(mcd));
        check("pause_timeout", 32'(bus.pause_timeout), 32'(mpto));
        check("run_cycles", bus.run_cycles, mrun);
    endtask

    task automatic cyc(input logic e, input logic [1:0] f);
        bus.en = e;
        bus.func = f;
        @(posedge clk);
        model_step(e, f);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.func = 2'b00;
        model_reset();
        idle(2);
        check("reset_state", 32'(bus.game_state), 32'(E_IDLE));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'b01);
            check("en0_no_change", 32'(bus.state_changed), 32'd0);
        end
        check("en0_idle", 32'(bus.game_state), 32'(E_IDLE));
        cyc(1'b1, 2'b01);
        check("cd_entry_state", 32'(bus.game_state), 32'(E_CD));
        check("cd_entry_left", 32'(bus.countdown_left), 32'd3);
        check("cd_entry_pulse", 32'(bus.state_changed), 32'd1);
        idle(3);
        check("cd_last_left", 32'(bus.countdown_left), 32'd0);
        check("cd_last_state", 32'(bus.game_state), 32'(E_CD));
        idle(1);
        check("run_entry", 32'(bus.game_state), 32'(E_RUN));
        idle(9);
        cyc(1'b1, 2'b11);
        check("paused", 32'(bus.game_state), 32'(E_PAUSE));
        check("run_at_pause", bus.run_cycles, 32'd10);
        idle(4);
        cyc(1'b1, 2'b11);
        check("run_frozen_in_pause", bus.run_cycles, 32'd10);
        idle(2);
        cyc(1'b1, 2'b10);
        check("run_total", bus.run_cycles, 32'd13);
        check("stopped", 32'(bus.game_state), 32'(E_STOP));
        cyc(1'b1, 2'b11);
        cyc(1'b1, 2'b10);
        idle(2);
        check("stop_holds", bus.run_cycles, 32'd13);
        cyc(1'b1, 2'b01);
        check("restart_clears_run", bus.run_cycles, 32'd0);
        idle(4);
        cyc(1'b1, 2'b01);
        cyc(1'b1, 2'b11);
        idle(7);
        check("pause_before_timeout", 32'(bus.game_state), 32'(E_PAUSE));
        idle(1);
        check("timeout_stop", 32'(bus.game_state), 32'(E_STOP));
        check("timeout_flag", 32'(bus.pause_timeout), 32'd1);
        idle(2);
        cyc(1'b1, 2'b01);
        check("start_clears_flag", 32'(bus.pause_timeout), 32'd0);
        idle(4);
        cyc(1'b1, 2'b11);
        idle(7);
        cyc(1'b1, 2'b11);
        check("toggle_on_timeout", 32'(bus.game_state), 32'(E_RUN));
        check("toggle_no_flag", 32'(bus.pause_timeout), 32'd0);
        cyc(1'b1, 2'b11);
        idle(7);
        cyc(1'b1, 2'b10);
        check("end_on_timeout", 32'(bus.game_state), 32'(E_STOP));
        check("end_no_flag", 32'(bus.pause_timeout), 32'd0);
        cyc(1'b1, 2'b01);
        idle(1);
        cyc(1'b1, 2'b10);
        check("cd_abort", 32'(bus.game_state), 32'(E_STOP));
        check("cd_abort_left", 32'(bus.countdown_left), 32'd0);
        cyc(1'b1, 2'b01);
        idle(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_state", 32'(bus.game_state), 32'(E_IDLE));
        check("async_rst_left", 32'(bus.countdown_left), 32'd0);
        check("async_rst_run", bus.run_cycles, 32'd0);
        idle(2);
        rst_n = 1'b1;
        cyc(1'b1, 2'b01);
        check("post_rst_start", 32'(bus.game_state), 32'(E_CD));
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
